if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage in-order MIPS pipeline, directly upstream of `id_stage`. It holds a pre-IF PC register and issues one instruction-SRAM read at a time over the SRAM-like req/addr_ok/data_ok interface. It buffers the returned instruction until ID accepts it and delivers `{inst, pc}` on `fs_to_ds_bus`. It consumes ID's `br_bus` and redirects fetch after the branch delay slot.

## Interface
- `RESET_PC`, default 32'hBFC00000: first fetch address after reset.
- `clk`  in  1: clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high.
- `ds_allowin`  in  1: ID can accept an instruction this cycle.
- `br_bus`  in  34: {br_stall[33], br_taken[32], br_target[31:0]} from ID.
- `fs_to_ds_valid`  out  1: an instruction is offered to ID.
- `fs_to_ds_bus`  out  64: {inst[63:32], pc[31:0]}.
- `inst_sram_req`  out  1: read request.
- `inst_sram_wr`  out  1: constant 0.
- `inst_sram_size`  out  2: constant 2'd2.
- `inst_sram_wstrb`  out  4: constant 0.
- `inst_sram_addr`  out  32: the value of the pfs_pc register.
- `inst_sram_wdata`  out  32: constant 0.
- `inst_sram_addr_ok`  in  1: request accepted; handshake completes when `req && addr_ok`.
- `inst_sram_rdata`  in  32: read data, valid with `data_ok`.
- `inst_sram_data_ok`  in  1: read data returned, at least 1 cycle after `addr_ok`.

## Operation
- State:
  - pfs_pc[31:0]
  - fs_valid
  - fs_pc[31:0]
  - buf_valid, buf_inst[31:0]: captured rdata
  - bb_valid, bb_target[31:0]: pending branch redirect
  - br_guard: the branch currently in ID has already been taken into account
- Derived signals:
  - fs_ready_go = buf_valid || (fs_valid && data_ok).
  - fs_to_ds_valid = fs_valid && fs_ready_go.
  - deliver = fs_to_ds_valid && ds_allowin.
  - fs_allowin = !fs_valid || (fs_ready_go && ds_allowin).
  - capture = br_taken && !br_stall && !br_guard.
- inst_sram_req = !reset && fs_allowin && !br_stall && !(capture && fs_valid).
- accept = req && addr_ok. At most one read is outstanding.
- Bus `inst` = buf_valid ? buf_inst : rdata.
- Bus `pc` = fs_valid ? fs_pc : pfs_pc. This is always the PC of the next instruction ID will receive, i.e. the delay-slot PC that ID uses for beq/bne targets.
- FS update:
  - accept → fs_valid=1, fs_pc=pfs_pc, buf_valid=0.
  - deliver without accept → fs_valid=0, buf_valid=0.
  - data_ok && fs_valid && !deliver && !buf_valid → buf_valid=1, buf_inst=rdata.
  - data_ok with !fs_valid → ignored.
- pfs_pc update, first matching rule wins:
  1. capture && fs_valid (delay slot already in FS; req suppressed this cycle) → pfs_pc=br_target.
  2. capture && !fs_valid && accept (delay slot issued now) → pfs_pc=br_target.
  3. capture && !fs_valid && !accept → bb_valid=1, bb_target=br_target; pfs_pc unchanged.
  4. bb_valid && accept → pfs_pc=bb_target, bb_valid=0.
  5. accept → pfs_pc=pfs_pc+4, mod 2^32 (wrap 32'hFFFFFFFC → 0).
- br_guard next value:
  - deliver → 0. This takes priority over capture in the same cycle.
  - else capture → 1.
  - else hold.
- Wrong-path fetch never occurs: no address beyond the delay slot is issued before the target is known.
- br_stall=1 → no request, no capture; all state holds apart from FS data capture.

## Timing
- Reset values:
  - pfs_pc=RESET_PC.
  - fs_valid, buf_valid, bb_valid, br_guard = 0.
  - req=0 and fs_to_ds_valid=0 while reset is high.
- First request: the first cycle after reset deasserts, with addr=RESET_PC.
- Latency: accept at cycle t, data_ok at t+k → fs_to_ds_valid at t+k (rdata bypass).
- Throughput: with k=1 and ds_allowin=1, a new accept can occur in the data_ok cycle, giving 1 instruction/cycle.
- ID stalled: data is held in buf; req stays 0 until delivery.
- Reset mid-operation: all state returns to reset values next cycle. Memory is reset with the core, so no stale data_ok arrives.

## Test plan
- Reset release, addr_ok=1 always, data_ok 1 cycle later, ds_allowin=1 → addrs BFC00000, BFC00004, BFC00008 on consecutive cycles; ID receives pcs in order with matching rdata.
- ds_allowin=0 for 3 cycles after data_ok → fs_to_ds_valid held, inst stable from buf, req=0; on release the instruction is delivered once and the next req follows.
- br_taken with target 0xBFC00100, asserted while the delay slot is in FS → next issued addr = 0xBFC00100; no addr delay_slot+4 issued.
- br_taken while FS is empty and addr_ok=0 for 2 cycles → bb_valid set; delay slot issued, then target; bus pc equals the delay-slot PC during capture.
- br_stall=1 for 4 cycles with br_taken=1 → req=0 throughout; target issued after br_stall drops.
- Reset asserted mid-stream → fs_to_ds_valid=0 next cycle; fetch restarts at BFC00000.

Source files
------------

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bundle: ID handshake, branch bus and instruction SRAM port
interface if_stage_if;
    logic        ds_allowin;
    logic [33:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_data_ok;

    modport master (
        input  ds_allowin, br_bus,
        input  inst_sram_addr_ok, inst_sram_rdata, inst_sram_data_ok,
        output fs_to_ds_valid, fs_to_ds_bus,
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
        output inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output ds_allowin, br_bus,
        output inst_sram_addr_ok, inst_sram_rdata, inst_sram_data_ok,
        input  fs_to_ds_valid, fs_to_ds_bus,
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
        input  inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch stage with one outstanding SRAM read and delay-slot redirect
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic         clk,
    input  logic         reset,
    if_stage_if.master   bus
);
    logic [31:0] pfs_pc_q, pfs_pc_d;
    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        bb_valid_q, bb_valid_d;
    logic [31:0] bb_target_q, bb_target_d;
    logic        br_guard_q, br_guard_d;

    logic        br_stall, br_taken;
    logic [31:0] br_target;
    logic        fs_ready_go, fs_to_ds_valid, deliver, fs_allowin;
    logic        capture, req, accept, data_ok;

    assign br_stall  = bus.br_bus[33];
    assign br_taken  = bus.br_bus[32];
    assign br_target = bus.br_bus[31:0];
    assign data_ok   = bus.inst_sram_data_ok;

    assign fs_ready_go    = buf_valid_q || (fs_valid_q && data_ok);
    assign fs_to_ds_valid = !reset && fs_valid_q && fs_ready_go;
    assign deliver        = fs_to_ds_valid && bus.ds_allowin;
    assign fs_allowin     = !fs_valid_q || (fs_ready_go && bus.ds_allowin);
    assign capture        = br_taken && !br_stall && !br_guard_q;
    // With the delay slot already in FS, hold off so pfs_pc can switch to the target first.
    assign req            = !reset && fs_allowin && !br_stall && !(capture && fs_valid_q);
    assign accept         = req && bus.inst_sram_addr_ok;

    assign bus.fs_to_ds_valid  = fs_to_ds_valid;
    assign bus.fs_to_ds_bus    = {(buf_valid_q ? buf_inst_q : bus.inst_sram_rdata),
                                  (fs_valid_q ? fs_pc_q : pfs_pc_q)};
    assign bus.inst_sram_req   = req;
    assign bus.inst_sram_wr    = 1'b0;
    assign bus.inst_sram_size  = 2'd2;
    assign bus.inst_sram_wstrb = 4'd0;
    assign bus.inst_sram_addr  = pfs_pc_q;
    assign bus.inst_sram_wdata = 32'd0;

    always_comb begin
        fs_valid_d  = fs_valid_q;
        fs_pc_d     = fs_pc_q;
        buf_valid_d = buf_valid_q;
        buf_inst_d  = buf_inst_q;
        if (accept) begin
            fs_valid_d  = 1'b1;
            fs_pc_d     = pfs_pc_q;
            buf_valid_d = 1'b0;
        end else if (deliver) begin
            fs_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
        end else if (data_ok && fs_valid_q && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_inst_d  = bus.inst_sram_rdata;
        end
    end

    always_comb begin
        pfs_pc_d    = pfs_pc_q;
        bb_valid_d  = bb_valid_q;
        bb_target_d = bb_target_q;
        if (capture && fs_valid_q) begin
            pfs_pc_d = br_target;
        end else if (capture && accept) begin
            pfs_pc_d = br_target;
        end else if (capture) begin
            bb_valid_d  = 1'b1;
            bb_target_d = br_target;
        end else if (bb_valid_q && accept) begin
            pfs_pc_d   = bb_target_q;
            bb_valid_d = 1'b0;
        end else if (accept) begin
            pfs_pc_d = pfs_pc_q + 32'd4;
        end
    end

    // Guard clears when the branch leaves ID, so a new branch in ID is seen even if it follows at once.
    always_comb begin
        br_guard_d = br_guard_q;
        if (deliver) begin
            br_guard_d = 1'b0;
        end else if (capture) begin
            br_guard_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pfs_pc_q    <= RESET_PC;
            fs_valid_q  <= 1'b0;
            fs_pc_q     <= 32'd0;
            buf_valid_q <= 1'b0;
            buf_inst_q  <= 32'd0;
            bb_valid_q  <= 1'b0;
            bb_target_q <= 32'd0;
            br_guard_q  <= 1'b0;
        end else begin
            pfs_pc_q    <= pfs_pc_d;
            fs_valid_q  <= fs_valid_d;
            fs_pc_q     <= fs_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
            bb_valid_q  <= bb_valid_d;
            bb_target_q <= bb_target_d;
            br_guard_q  <= br_guard_d;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed bench for if_stage with a one-cycle-latency instruction SRAM
module tb_if_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    if_stage_if bus();

    if_stage #(.RESET_PC(32'hBFC00000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] issued[$];
    logic [31:0] deliv_pc[$];
    logic [31:0] deliv_inst[$];

    assign bus.inst_sram_data_ok = pend;
    assign bus.inst_sram_rdata   = pend ? ~pend_addr : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (!reset && bus.inst_sram_req && bus.inst_sram_addr_ok)
            issued.push_back(bus.inst_sram_addr);
        if (bus.fs_to_ds_valid && bus.ds_allowin) begin
            deliv_pc.push_back(bus.fs_to_ds_bus[31:0]);
            deliv_inst.push_back(bus.fs_to_ds_bus[63:32]);
        end
        if (reset) begin
            pend <= 1'b0;
        end else begin
            pend <= bus.inst_sram_req && bus.inst_sram_addr_ok;
            if (bus.inst_sram_req && bus.inst_sram_addr_ok)
                pend_addr <= bus.inst_sram_addr;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] fbus(input logic [31:0] pc);
        return {~pc, pc};
    endfunction

    initial begin
        logic [31:0] exp_issued [10];
        logic [31:0] exp_deliv [8];
        exp_issued = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C, 32'hBFC00100,
                       32'hBFC00104, 32'hBFC00200, 32'hBFC00204, 32'hBFC00300, 32'hBFC00000};
        exp_deliv  = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C,
                       32'hBFC00100, 32'hBFC00104, 32'hBFC00200, 32'hBFC00204};

        bus.ds_allowin = 1'b1;
        bus.br_bus = 34'd0;
        bus.inst_sram_addr_ok = 1'b1;

        // Reset
        cyc; cyc; #1;
        check("rst_req", 64'(bus.inst_sram_req), 64'd0);
        check("rst_valid", 64'(bus.fs_to_ds_valid), 64'd0);
        check("rst_addr", 64'(bus.inst_sram_addr), 64'hBFC00000);
        check("consts", {bus.inst_sram_wdata, 25'd0, bus.inst_sram_wr, bus.inst_sram_size, bus.inst_sram_wstrb},
              {32'd0, 25'd0, 1'b0, 2'd2, 4'd0});
        reset = 1'b0; #1;
        // cycle 0: first request
        check("c0_req", 64'(bus.inst_sram_req), 64'd1);
        check("c0_addr", 64'(bus.inst_sram_addr), 64'hBFC00000);
        cyc; #1;  // cycle 1
        check("c1_valid", 64'(bus.fs_to_ds_valid), 64'd1);
        check("c1_bus", bus.fs_to_ds_bus, fbus(32'hBFC00000));
        check("c1_addr", {31'd0, bus.inst_sram_req, bus.inst_sram_addr}, {31'd0, 1'b1, 32'hBFC00004});
        cyc; #1;  // cycle 2
        check("c2_bus", bus.fs_to_ds_bus, fbus(32'hBFC00004));
        check("c2_addr", {31'd0, bus.inst_sram_req, bus.inst_sram_addr}, {31'd0, 1'b1, 32'hBFC00008});

        // ID stall for cycles 3..5
        cyc; bus.ds_allowin = 1'b0; #1;  // cycle 3
        check("c3_valid", 64'(bus.fs_to_ds_valid), 64'd1);
        check("c3_bus", bus.fs_to_ds_bus, fbus(32'hBFC00008));
        check("c3_req", 64'(bus.inst_sram_req), 64'd0);
        cyc; #1;  // cycle 4
        check("c4_hold", {31'd0, bus.fs_to_ds_valid, 31'd0, bus.inst_sram_req}, {31'd0, 1'b1, 31'd0, 1'b0});
        check("c4_bus", bus.fs_to_ds_bus, fbus(32'hBFC00008));
        cyc; #1;  // cycle 5
        check("c5_bus", bus.fs_to_ds_bus, fbus(32'hBFC00008));
        check("c5_req", 64'(bus.inst_sram_req), 64'd0);
        cyc; bus.ds_allowin = 1'b1; #1;  // cycle 6: release
        check("c6_bus", bus.fs_to_ds_bus, fbus(32'hBFC00008));
        check("c6_addr", {31'd0, bus.inst_sram_req, bus.inst_sram_addr}, {31'd0, 1'b1, 32'hBFC0000C});

        // Branch taken with delay slot in FS
        cyc; bus.br_bus = {1'b0, 1'b1, 32'hBFC00100}; #1;  // cycle 7
        check("c7_req", 64'(bus.inst_sram_req), 64'd0);
        check("c7_bus", bus.fs_to_ds_bus, fbus(32'hBFC0000C));
        cyc; bus.br_bus = 34'd0; #1;  // cycle 8
        check("c8_addr", {31'd0, bus.inst_sram_req, bus.inst_sram_addr}, {31'd0, 1'b1, 32'hBFC00100});

        // Branch taken with FS empty and addr_ok low
        cyc; bus.inst_sram_addr_ok = 1'b0; #1;  // cycle 9
        check("c9_bus", bus.fs_to_ds_bus, fbus(32'hBFC00100));
        cyc; bus.br_bus = {1'b0, 1'b1, 32'hBFC00200}; #1;  // cycle 10
        check("c10_valid", 64'(bus.fs_to_ds_valid), 64'd0);
        check("c10_pc", 64'(bus.fs_to_ds_bus[31:0]), 64'hBFC00104);
        check("c10_addr", {31'd0, bus.inst_sram_req, bus.inst_sram_addr}, {31'd0, 1'b1, 32'hBFC00104});
        cyc; #1;  // cycle 11
        check("c11_addr", {31'd0, bus.inst_sram_req, bus.inst_sram_addr}, {31'd0, 1'b1, 32'hBFC00104});
        cyc; bus.inst_sram_addr_ok = 1'b1; #1;  // cycle 12
        check("c12_addr", 64'(bus.inst_sram_addr), 64'hBFC00104);
        cyc; #1;  // cycle 13
        check("c13_bus", bus.fs_to_ds_bus, fbus(32'hBFC00104));
        check("c13_addr", {31'd0, bus.inst_sram_req, bus.inst_sram_addr}, {31'd0, 1'b1, 32'hBFC00200});

        // Branch held behind br_stall for 4 cycles
        cyc; bus.br_bus = {1'b1, 1'b1, 32'hBFC00300}; #1;  // cycle 14
        check("c14_req", 64'(bus.inst_sram_req), 64'd0);
        for (int i = 15; i <= 17; i++) begin
            cyc; #1;
            check($sformatf("c%0d_stall_req", i), 64'(bus.inst_sram_req), 64'd0);
        end
        cyc; bus.br_bus = {1'b0, 1'b1, 32'hBFC00300}; #1;  // cycle 18
        check("c18_addr", {31'd0, bus.inst_sram_req, bus.inst_sram_addr}, {31'd0, 1'b1, 32'hBFC00204});
        cyc; #1;  // cycle 19
        check("c19_bus", bus.fs_to_ds_bus, fbus(32'hBFC00204));
        check("c19_addr", {31'd0, bus.inst_sram_req, bus.inst_sram_addr}, {31'd0, 1'b1, 32'hBFC00300});

        // Reset mid-stream
        cyc; bus.br_bus = 34'd0; reset = 1'b1; #1;  // cycle 20
        check("c20_rst", {31'd0, bus.fs_to_ds_valid, 31'd0, bus.inst_sram_req}, 64'd0);
        cyc; #1;  // cycle 21
        check("c21_valid", 64'(bus.fs_to_ds_valid), 64'd0);
        reset = 1'b0; #1;
        check("c21_addr", {31'd0, bus.inst_sram_req, bus.inst_sram_addr}, {31'd0, 1'b1, 32'hBFC00000});
        cyc; #1;  // cycle 22
        check("c22_bus", bus.fs_to_ds_bus, fbus(32'hBFC00000));

        check("issued_cnt", 64'(issued.size()), 64'd10);
        for (int i = 0; i < 10 && i < issued.size(); i++)
            check($sformatf("issued_%0d", i), 64'(issued[i]), 64'(exp_issued[i]));
        check("deliv_cnt", 64'(deliv_pc.size()), 64'd8);
        for (int i = 0; i < 8 && i < deliv_pc.size(); i++)
            check($sformatf("deliv_%0d", i), {deliv_inst[i], deliv_pc[i]}, fbus(exp_deliv[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
